// File: rtl/apb4_rr_arbiter.sv
// Round-robin arbiter that shares one APB4 master port among NUM_REQ single-beat requesters.
// One transfer in flight at a time; a programmable timeout aborts hung ACCESS phases.
module apb4_rr_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_strb,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            rsp_err,
  output logic                            timeout_evt,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic [ADDR_WIDTH-1:0]           paddr,
  output logic                            pwrite,
  output logic [DATA_WIDTH-1:0]           pwdata,
  output logic [DATA_WIDTH/8-1:0]         pstrb,
  output logic                            psel,
  output logic                            penable,
  input  logic [DATA_WIDTH-1:0]           prdata,
  input  logic                            pready,
  input  logic                            pslverr
);

  localparam int IW     = $clog2(NUM_REQ);
  localparam int SW     = DATA_WIDTH / 8;
  localparam int TW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TLIM_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic          TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0] TLIM    = TW'(TLIM_I);
  localparam logic [TW-1:0] TMAX    = {TW{1'b1}};
  localparam logic [NUM_REQ-1:0] ONE_REQ = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t r_state, w_state_nxt;
  logic [IW-1:0]         r_ptr, r_grant, w_winner, w_idx, w_next_ptr;
  logic                  w_found, w_accept, w_done, w_timeout;
  logic [ADDR_WIDTH-1:0] r_paddr, w_sel_addr;
  logic [DATA_WIDTH-1:0] r_pwdata, w_sel_wdata, r_rsp_rdata;
  logic [SW-1:0]         r_pstrb, w_sel_strb;
  logic                  r_pwrite, w_sel_write;
  logic                  r_psel, r_penable, r_rsp_err, r_timeout_evt;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic [TW-1:0]         r_tcnt;

  // Winner search: scanning offsets downward lets the smallest offset from ptr win.
  always_comb begin
    w_winner = r_ptr;
    w_found  = 1'b0;
    w_idx    = {IW{1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx    = IW'((int'(r_ptr) + k) % NUM_REQ);
      w_found  = w_found | req_valid[w_idx];
      w_winner = req_valid[w_idx] ? w_idx : w_winner;
    end
  end

  // Command mux selecting the winning requester's slice.
  always_comb begin
    w_sel_addr  = {ADDR_WIDTH{1'b0}};
    w_sel_wdata = {DATA_WIDTH{1'b0}};
    w_sel_strb  = {SW{1'b0}};
    w_sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel_addr  = (w_winner == IW'(i)) ? req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] : w_sel_addr;
      w_sel_wdata = (w_winner == IW'(i)) ? req_wdata[i*DATA_WIDTH +: DATA_WIDTH] : w_sel_wdata;
      w_sel_strb  = (w_winner == IW'(i)) ? req_strb[i*SW +: SW] : w_sel_strb;
      w_sel_write = (w_winner == IW'(i)) ? req_write[i] : w_sel_write;
    end
  end

  assign w_accept   = (r_state == S_IDLE) & w_found;
  assign w_next_ptr = IW'((int'(w_winner) + 1) % NUM_REQ);
  assign req_ready  = w_accept ? (ONE_REQ << w_winner) : {NUM_REQ{1'b0}};
  assign w_done     = (r_state == S_ACCESS) & pready;
  // r_tcnt counts completed ACCESS cycles, so TLIM marks the last permitted one.
  assign w_timeout  = TO_EN & (r_state == S_ACCESS) & ~pready & (r_tcnt == TLIM);

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_found) w_state_nxt = S_SETUP;
        else         w_state_nxt = S_IDLE;
      end
      S_SETUP: w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (pready || w_timeout) w_state_nxt = S_RESP;
        else                     w_state_nxt = S_ACCESS;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, round-robin pointer and grant index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= {IW{1'b0}};
      r_grant <= {IW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_ptr   <= w_next_ptr;
        r_grant <= w_winner;
      end
    end
  end

  // Command latch; reads never drive strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_paddr  <= {ADDR_WIDTH{1'b0}};
      r_pwrite <= 1'b0;
      r_pwdata <= {DATA_WIDTH{1'b0}};
      r_pstrb  <= {SW{1'b0}};
    end else if (w_accept) begin
      r_paddr  <= w_sel_addr;
      r_pwrite <= w_sel_write;
      r_pwdata <= w_sel_wdata;
      r_pstrb  <= w_sel_write ? w_sel_strb : {SW{1'b0}};
    end
  end

  // APB phase controls follow the next state so they are glitch-free flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
    end else begin
      r_psel    <= (w_state_nxt == S_SETUP) | (w_state_nxt == S_ACCESS);
      r_penable <= (w_state_nxt == S_ACCESS);
    end
  end

  // ACCESS-cycle counter; saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= {TW{1'b0}};
    end else if (r_state == S_SETUP) begin
      r_tcnt <= {TW{1'b0}};
    end else if ((r_state == S_ACCESS) && (r_tcnt != TMAX)) begin
      r_tcnt <= r_tcnt + TW'(1'b1);
    end
  end

  // Response capture and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid   <= {NUM_REQ{1'b0}};
      r_rsp_rdata   <= {DATA_WIDTH{1'b0}};
      r_rsp_err     <= 1'b0;
      r_timeout_evt <= 1'b0;
    end else begin
      r_rsp_valid   <= (w_state_nxt == S_RESP) ? (ONE_REQ << r_grant) : {NUM_REQ{1'b0}};
      r_timeout_evt <= w_timeout;
      if (w_done) begin
        r_rsp_rdata <= r_pwrite ? {DATA_WIDTH{1'b0}} : prdata;
        r_rsp_err   <= pslverr;
      end else if (w_timeout) begin
        r_rsp_rdata <= {DATA_WIDTH{1'b0}};
        r_rsp_err   <= 1'b1;
      end
    end
  end

  assign paddr       = r_paddr;
  assign pwrite      = r_pwrite;
  assign pwdata      = r_pwdata;
  assign pstrb       = r_pstrb;
  assign psel        = r_psel;
  assign penable     = r_penable;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign timeout_evt = r_timeout_evt;
  assign grant_id    = r_grant;

endmodule

// File: tb/tb_apb4_rr_arbiter.sv
// Bench for apb4_rr_arbiter: vector table plus hand sequences, responses checked through a queue.
module tb_apb4_rr_arbiter;
  localparam int NR = 4, AW = 16, DW = 32, SW = 4, TO = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [NR-1:0]    req_valid = '0, req_write = '0;
  logic [NR*AW-1:0] req_addr  = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR*SW-1:0] req_strb  = '0;
  logic [NR-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]    rsp_rdata, pwdata;
  logic             rsp_err, timeout_evt, pwrite, psel, penable;
  logic [1:0]       grant_id;
  logic [AW-1:0]    paddr;
  logic [SW-1:0]    pstrb;
  logic [DW-1:0]    prdata  = '0;
  logic             pready  = 1'b0, pslverr = 1'b0;

  apb4_rr_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .timeout_evt(timeout_evt),
    .grant_id(grant_id), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .psel(psel), .penable(penable), .prdata(prdata), .pready(pready), .pslverr(pslverr));

  always #5 clk = ~clk;

  typedef struct {
    int id; bit wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [SW-1:0] strb;
    int waits;        // ACCESS wait states before pready; -1 = never ready
    bit slverr; logic [DW-1:0] prd;
    logic [DW-1:0] exp_rdata; bit exp_err; bit exp_tevt;
    int exp_lat;      // cycles from acceptance cycle to rsp_valid cycle
  } vec_t;

  typedef struct { int id; logic [DW-1:0] rdata; bit err; bit tevt; int cyc; } exp_t;

  int   checks = 0, failures = 0, cyc = 0, acc_n = 0;
  exp_t sb[$];
  vec_t cur;
  vec_t vecs[7];

  function automatic vec_t mk(int id, bit wr, logic [AW-1:0] addr, logic [DW-1:0] wdata,
                              logic [SW-1:0] strb, int waits, bit slverr, logic [DW-1:0] prd,
                              logic [DW-1:0] er, bit ee, bit et, int lat);
    vec_t v;
    v.id = id; v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.waits = waits;
    v.slverr = slverr; v.prd = prd; v.exp_rdata = er; v.exp_err = ee; v.exp_tevt = et;
    v.exp_lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral model and output monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (psel && penable) acc_n = acc_n + 1;
    else                 acc_n = 0;
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    if (psel && penable && cur.waits >= 0 && acc_n == cur.waits + 1) begin
      pready = 1'b1; pslverr = cur.slverr; prdata = cur.prd;
    end
    if (psel) begin
      chk("paddr",  64'(paddr),  64'(cur.addr));
      chk("pwrite", 64'(pwrite), 64'(cur.wr));
      chk("pwdata", 64'(pwdata), 64'(cur.wdata));
      chk("pstrb",  64'(pstrb),  64'(cur.wr ? cur.strb : 4'h0));
    end
    if (rsp_valid != 4'h0) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL spurious_rsp: got rsp_valid=%0h, required none (cycle %0d)", rsp_valid, cyc);
      end else begin
        e = sb.pop_front();
        chk("rsp_valid_id", 64'(rsp_valid),   64'(4'b0001 << e.id));
        chk("rsp_rdata",    64'(rsp_rdata),   64'(e.rdata));
        chk("rsp_err",      64'(rsp_err),     64'(e.err));
        chk("timeout_evt",  64'(timeout_evt), 64'(e.tevt));
        chk("rsp_cycle",    64'(cyc),         64'(e.cyc));
      end
    end else begin
      chk("tevt_idle", 64'(timeout_evt), 64'(1'b0));
    end
  end

  task automatic set_cmd(input vec_t v);
    req_addr[v.id*AW +: AW]  = v.addr;
    req_write[v.id]          = v.wr;
    req_wdata[v.id*DW +: DW] = v.wdata;
    req_strb[v.id*SW +: SW]  = v.strb;
  endtask

  task automatic accept_one(input int exp_id, input vec_t v, input bit drop, output int got);
    bit   seen;
    exp_t e;
    got = -1;
    #1 seen = (req_ready != 4'h0);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk); #1 seen = (req_ready != 4'h0);
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL accept_wait: got no req_ready in 40 cycles, required grant to %0d", exp_id);
    end else begin
      for (int b = 0; b < NR; b++) if (req_ready[b]) got = b;
      chk("req_ready", 64'(req_ready), 64'(4'b0001 << exp_id));
      cur = v;
      e.id = exp_id; e.rdata = v.exp_rdata; e.err = v.exp_err; e.tevt = v.exp_tevt;
      e.cyc = cyc + v.exp_lat;
      sb.push_back(e);
      @(posedge clk); #1;
      if (drop) req_valid[exp_id] = 1'b0;
      chk("grant_id", 64'(grant_id), 64'(exp_id));
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_wait: got %0d pending responses, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    vec_t fv[NR];
    vec_t a, b, vr;
    int   got, nacc;
    int   gcnt[NR];

    // id, wr, addr, wdata, strb, waits, slverr, prdata, exp_rdata, exp_err, exp_tevt, latency
    vecs[0] = mk(1, 0, 16'h0040, 32'h0000_0000, 4'hF, 0,  0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 3);
    vecs[1] = mk(0, 1, 16'h0100, 32'h1234_5678, 4'h5, 3,  0, 32'hFFFF_FFFF, 32'h0,         0, 0, 6);
    vecs[2] = mk(2, 0, 16'h0200, 32'h0000_0000, 4'hF, -1, 0, 32'h5555_5555, 32'h0,         1, 1, 10);
    vecs[3] = mk(3, 0, 16'h0300, 32'h0000_0000, 4'hF, 7,  0, 32'h0BAD_F00D, 32'h0BAD_F00D, 0, 0, 10);
    vecs[4] = mk(3, 1, 16'h0304, 32'hC3C3_3C3C, 4'hA, 2,  0, 32'h7777_7777, 32'h0,         0, 0, 5);
    vecs[5] = mk(2, 1, 16'h0208, 32'hA5A5_A5A5, 4'hF, 0,  1, 32'h0,         32'h0,         1, 0, 3);
    vecs[6] = mk(1, 0, 16'h0044, 32'h0000_0000, 4'h3, 1,  1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 0, 4);
    cur = mk(0, 0, 16'h0, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_psel",     64'(psel),        64'(1'b0));
    chk("rst_penable",  64'(penable),     64'(1'b0));
    chk("rst_paddr",    64'(paddr),       64'(16'h0));
    chk("rst_pwrite",   64'(pwrite),      64'(1'b0));
    chk("rst_pwdata",   64'(pwdata),      64'(32'h0));
    chk("rst_pstrb",    64'(pstrb),       64'(4'h0));
    chk("rst_rsp_valid",64'(rsp_valid),   64'(4'h0));
    chk("rst_rsp_rdata",64'(rsp_rdata),   64'(32'h0));
    chk("rst_rsp_err",  64'(rsp_err),     64'(1'b0));
    chk("rst_tevt",     64'(timeout_evt), 64'(1'b0));
    chk("rst_grant_id", 64'(grant_id),    64'(2'd0));
    chk("rst_req_ready",64'(req_ready),   64'(4'h0));

    // Fairness: every requester valid from reset release; expect 0,1,2,3,0,1,2,3.
    for (int i = 0; i < NR; i++) begin
      fv[i] = mk(i, 0, 16'(16'h0100 + 16 * i), 32'(32'h1111_0000 + i), 4'hF, 0, 0,
                 32'(32'hA000_0000 + i), 32'(32'hA000_0000 + i), 0, 0, 3);
      set_cmd(fv[i]);
      gcnt[i] = 0;
    end
    req_valid = 4'hF;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int g = 0; g < 2 * NR; g++) begin
      accept_one(g % NR, fv[g % NR], 1'b0, got);
      if (got >= 0) gcnt[got]++;
    end
    req_valid = 4'h0;
    for (int i = 0; i < NR; i++) chk("fair_count", 64'(gcnt[i]), 64'(2));
    wait_drain();

    for (int i = 0; i < 7; i++) begin
      set_cmd(vecs[i]);
      req_valid[vecs[i].id] = 1'b1;
      accept_one(vecs[i].id, vecs[i], 1'b1, got);
      wait_drain();
    end

    // Last vector was requester 1 with pslverr; ptr must now favour requester 2.
    a = mk(1, 0, 16'h0048, 32'h0, 4'h0, 0, 0, 32'h1357_9BDF, 32'h1357_9BDF, 0, 0, 3);
    b = mk(2, 1, 16'h020C, 32'h2468_ACE0, 4'hC, 0, 0, 32'h0, 32'h0, 0, 0, 3);
    set_cmd(a); set_cmd(b);
    req_valid = 4'b0110;
    accept_one(2, b, 1'b1, got);
    accept_one(1, a, 1'b1, got);
    wait_drain();

    // Reset in the middle of a hung ACCESS phase.
    vr = mk(0, 0, 16'h0500, 32'h0, 4'h0, -1, 0, 32'h0, 32'h0, 1, 1, 10);
    set_cmd(vr);
    req_valid[0] = 1'b1;
    accept_one(0, vr, 1'b1, got);
    nacc = 0;
    for (int i = 0; i < 20 && nacc < 3; i++) begin
      @(negedge clk); #1;
      if (psel && penable) nacc++;
    end
    chk("rst_mid_access_seen", 64'(nacc), 64'(3));
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("rst_mid_psel",    64'(psel),    64'(1'b0));
    chk("rst_mid_penable", 64'(penable), 64'(1'b0));
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    a = mk(0, 0, 16'h0600, 32'h0, 4'h0, 0, 0, 32'h0600_0600, 32'h0600_0600, 0, 0, 3);
    b = mk(2, 0, 16'h0700, 32'h0, 4'h0, 0, 0, 32'h0700_0700, 32'h0700_0700, 0, 0, 3);
    set_cmd(a); set_cmd(b);
    req_valid = 4'b0101;
    accept_one(0, a, 1'b1, got);
    accept_one(2, b, 1'b1, got);
    wait_drain();
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
